rf_link_sequencer: RTL and testbench

RF_LINK_SEQUENCER -- requirements
Module: rf_link_sequencer

---
 rtl/rf_link_sequencer_if.sv | 31 +++
 rtl/rf_link_sequencer.sv | 155 +++++++++++++++
 tb/tb_rf_link_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_link_sequencer_if.sv
// Handshake and RF-control bundle between a link controller and rf_link_sequencer.
// Latency: none, this is wiring only.
// Backpressure: bit_valid/bit_ready; a bit moves only when both are high.
// Ports: start/abort request a sequence or cancel it; carrier_detect is the raw envelope
//   comparator; bit_valid/bit_data/bit_ready carry payload bits; switch_control and
//   envelop_detector_enable drive the RF front end; busy/done/timeout report status.
interface rf_link_sequencer_if;
   logic start;
   logic abort;
   logic carrier_detect;
   logic bit_valid;
   logic bit_data;
   logic bit_ready;
   logic switch_control;
   logic envelop_detector_enable;
   logic busy;
   logic done;
   logic timeout;

   // master: the controller that requests sequences and supplies payload bits
   modport master (
      output start, abort, carrier_detect, bit_valid, bit_data,
      input  bit_ready, switch_control, envelop_detector_enable, busy, done, timeout
   );

   // slave: the sequencer itself
   modport slave (
      input  start, abort, carrier_detect, bit_valid, bit_data,
      output bit_ready, switch_control, envelop_detector_enable, busy, done, timeout
   );
endinterface

// File: rtl/rf_link_sequencer.sv
// Backscatter link sequencer: warm up detector, listen for carrier, FSK-modulate payload bits.
// Latency: carrier seen 2 cycles after carrier_detect (sync), TX entered the edge after.
// Backpressure: bit_ready pulses at each bit slot; a slot with no bit_valid ends the packet.
// Ports: clock, reset (async active-low), lnk (slave side of rf_link_sequencer_if).
module rf_link_sequencer #(
   parameter int WARMUP_CYCLES  = 64,
   parameter int LISTEN_TIMEOUT = 4096,
   parameter int HALF_PERIOD_0  = 4,
   parameter int HALF_PERIOD_1  = 3,
   parameter int BIT_CYCLES     = 24
) (
   input  logic                clock,
   input  logic                reset,
   rf_link_sequencer_if.slave  lnk
);

   localparam int M_A  = (WARMUP_CYCLES > LISTEN_TIMEOUT) ? WARMUP_CYCLES : LISTEN_TIMEOUT;
   localparam int M_B  = (HALF_PERIOD_0 > HALF_PERIOD_1) ? HALF_PERIOD_0 : HALF_PERIOD_1;
   localparam int M_C  = (M_A > M_B) ? M_A : M_B;
   localparam int MAXP = (M_C > BIT_CYCLES) ? M_C : BIT_CYCLES;
   localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

   localparam logic [CW-1:0] WARM_LAST   = CW'(WARMUP_CYCLES - 1);
   localparam logic [CW-1:0] LISTEN_LAST = CW'(LISTEN_TIMEOUT - 1);
   localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HP0_LAST    = CW'(HALF_PERIOD_0 - 1);
   localparam logic [CW-1:0] HP1_LAST    = CW'(HALF_PERIOD_1 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARMUP,
      S_LISTEN,
      S_TX,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, carrier_s_q;
   logic [CW-1:0]   cnt_q, cnt_d;          // WARMUP / LISTEN dwell counter
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;  // position inside the current bit
   logic [CW-1:0]   tog_cnt_q, tog_cnt_d;  // position inside the current half-period
   logic            cur_bit_q, cur_bit_d;
   logic            sw_q, sw_d;
   logic            timeout_q, timeout_d;
   logic            bit_ready;
   logic [CW-1:0]   half_last;

   // Slot for a new bit: first TX cycle (counter preloaded at entry) or the last cycle of a bit.
   assign bit_ready = (state_q == S_TX) && (bit_cnt_q == BIT_LAST);
   assign half_last = cur_bit_q ? HP1_LAST : HP0_LAST;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b0;
         carrier_s_q <= 1'b0;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         tog_cnt_q   <= '0;
         cur_bit_q   <= 1'b0;
         sw_q        <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= lnk.carrier_detect;
         carrier_s_q <= sync1_q;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         cur_bit_q   <= cur_bit_d;
         sw_q        <= sw_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      tog_cnt_d = tog_cnt_q;
      cur_bit_d = cur_bit_q;
      sw_d      = 1'b0;
      timeout_d = 1'b0;

      if (lnk.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (lnk.start) begin
                  state_d = S_WARMUP;
                  cnt_d   = '0;
               end
            end
            S_WARMUP: begin
               if (cnt_q == WARM_LAST) begin
                  state_d = S_LISTEN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_LISTEN: begin
               // Carrier is tested first so it wins in the final listen cycle.
               if (carrier_s_q) begin
                  state_d   = S_TX;
                  bit_cnt_d = BIT_LAST;
                  tog_cnt_d = '0;
               end else if (cnt_q == LISTEN_LAST) begin
                  state_d   = S_IDLE;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_TX: begin
               sw_d = sw_q;
               if (bit_ready) begin
                  if (lnk.bit_valid) begin
                     cur_bit_d = lnk.bit_data;
                     bit_cnt_d = '0;
                     tog_cnt_d = '0;
                     sw_d      = 1'b1;
                  end else begin
                     state_d = S_DONE;
                     sw_d    = 1'b0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (tog_cnt_q == half_last) begin
                     sw_d      = ~sw_q;
                     tog_cnt_d = '0;
                  end else begin
                     tog_cnt_d = tog_cnt_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign lnk.bit_ready               = bit_ready;
   assign lnk.switch_control          = sw_q;
   assign lnk.envelop_detector_enable = (state_q == S_WARMUP) || (state_q == S_LISTEN);
   assign lnk.busy                    = (state_q != S_IDLE);
   assign lnk.done                    = (state_q == S_DONE);
   assign lnk.timeout                 = timeout_q;

endmodule

// File: tb/tb_rf_link_sequencer.sv
// Randomized bench for rf_link_sequencer against a phase-level reference model.
// Latency: model tracks the 2-cycle carrier synchronizer as a plain delay line.
// Backpressure: payload bits offered only while the transaction plan has bits left.
module tb_rf_link_sequencer;
   localparam int WARM = 64;
   localparam int LT   = 4096;
   localparam int HP0  = 4;
   localparam int HP1  = 3;
   localparam int BC   = 24;

   logic clock;
   logic reset;

   rf_link_sequencer_if lnk();

   rf_link_sequencer #(
      .WARMUP_CYCLES (WARM),
      .LISTEN_TIMEOUT(LT),
      .HALF_PERIOD_0 (HP0),
      .HALF_PERIOD_1 (HP1),
      .BIT_CYCLES    (BC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .lnk  (lnk)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef enum int {P_IDLE, P_WARM, P_LISTEN, P_TX, P_DONE} phase_t;
   phase_t m_phase;
   int     m_n;      // cycles already spent in WARMUP / LISTEN
   int     m_pos;    // cycle index inside current bit, -1 before the first bit
   bit     m_cur;
   bit     m_tflag;
   bit     m_c1, m_c2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return (m_phase == P_TX) && (m_pos == -1 || m_pos == BC - 1);
   endfunction

   // Each bit is BC cycles of a square wave starting high, half-period set by the bit value.
   function automatic bit m_sw();
      int hp;
      hp = m_cur ? HP1 : HP0;
      return (m_phase == P_TX) && (m_pos >= 0) && (((m_pos / hp) % 2) == 0);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_n     = 0;
      m_pos   = -1;
      m_cur   = 1'b0;
      m_tflag = 1'b0;
      m_c1    = 1'b0;
      m_c2    = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit ab, input bit bv, input bit bd, input bit cd);
      bit cs;
      bit rdy;
      cs      = m_c2;
      rdy     = m_ready();
      m_c2    = m_c1;
      m_c1    = cd;
      m_tflag = 1'b0;
      if (ab) begin
         m_phase = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE:   if (st) begin m_phase = P_WARM; m_n = 0; end
            P_WARM:   if (m_n == WARM - 1) begin m_phase = P_LISTEN; m_n = 0; end else m_n++;
            P_LISTEN: begin
               if (cs) begin
                  m_phase = P_TX;
                  m_pos   = -1;
               end else if (m_n == LT - 1) begin
                  m_phase = P_IDLE;
                  m_tflag = 1'b1;
               end else begin
                  m_n++;
               end
            end
            P_TX: begin
               if (rdy) begin
                  if (bv) begin m_pos = 0; m_cur = bd; end
                  else m_phase = P_DONE;
               end else begin
                  m_pos++;
               end
            end
            P_DONE:   m_phase = P_IDLE;
            default:  m_phase = P_IDLE;
         endcase
      end
   endtask

   task automatic check_outputs();
      check_val("switch_control", lnk.switch_control, m_sw());
      check_val("bit_ready", lnk.bit_ready, m_ready());
      check_val("env_enable", lnk.envelop_detector_enable, (m_phase == P_WARM) || (m_phase == P_LISTEN));
      check_val("busy", lnk.busy, m_phase != P_IDLE);
      check_val("done", lnk.done, m_phase == P_DONE);
      check_val("timeout", lnk.timeout, m_tflag);
   endtask

   task automatic cycle(input bit rn, input bit st, input bit ab, input bit bv, input bit bd, input bit cd);
      @(negedge clock);
      cyc++;
      check_outputs();
      reset              = rn;
      lnk.start          = st;
      lnk.abort          = ab;
      lnk.bit_valid      = bv;
      lnk.bit_data       = bd;
      lnk.carrier_detect = cd;
      if (!rn) model_reset();
      else     model_step(st, ab, bv, bd, cd);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'b0, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // kind: 0 normal, 1 timeout, 2 abort mid-bit, 3 no bits, 4 carrier in last listen cycle,
   // 5 random abort. stop_pos >= 0 returns once TX reaches that position in a bit.
   task automatic run_txn(input int kind, input int stop_pos);
      int  c_on, bits, ab_pos, since;
      bit  started, left, finished;
      bit  st, ab, bv, bd, cd;
      c_on     = $urandom_range(0, 150);
      bits     = (kind == 3) ? 0 : $urandom_range(1, 5);
      ab_pos   = $urandom_range(1, BC - 2);
      since    = 0;
      started  = 1'b0;
      left     = 1'b0;
      finished = 1'b0;
      for (int k = 0; k < 9000; k++) begin
         st = 1'b0;
         if (!started && m_phase == P_IDLE) begin
            st      = 1'b1;
            started = 1'b1;
         end else if ($urandom_range(0, 15) == 0) begin
            st = 1'b1;
         end
         if (started) since++;

         if (m_phase == P_TX || m_phase == P_DONE) cd = 1'($urandom);
         else if (kind == 1) cd = 1'b0;
         else if (kind == 4) cd = (m_phase == P_LISTEN) && (m_n >= LT - 3);
         else cd = (since >= c_on);

         bd = 1'($urandom);
         if (m_ready()) bv = (bits > 0);
         else           bv = 1'($urandom);
         if (m_ready() && bv) bits--;

         ab = 1'b0;
         if (kind == 2) ab = (m_phase == P_TX) && (m_pos == ab_pos);
         if (kind == 5) ab = (m_phase != P_IDLE) && ($urandom_range(0, 39) == 0);

         cycle(1'b1, st, ab, bv, bd, cd);

         if (m_phase != P_IDLE) left = 1'b1;
         if (left && m_phase == P_IDLE) begin finished = 1'b1; break; end
         if (stop_pos >= 0 && m_phase == P_TX && m_pos == stop_pos) begin finished = 1'b1; break; end
      end
      if (!finished) check_val("txn_cycle_budget", 0, 1);
   endtask

   int kinds[$] = '{0, 0, 3, 0, 2, 0, 5, 0, 1, 0, 2, 3, 0, 5, 0, 4, 0, 2, 0, 5, 0, 3, 0, 5, 0, 2, 0, 0, 5, 0};

   initial begin
      reset              = 1'b1;
      lnk.start          = 1'b0;
      lnk.abort          = 1'b0;
      lnk.bit_valid      = 1'b0;
      lnk.bit_data       = 1'b0;
      lnk.carrier_detect = 1'b0;
      model_reset();
      #1 reset = 1'b0;

      // reset state, start held during reset must be ignored
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle_cycles(3);

      foreach (kinds[i]) begin
         run_txn(kinds[i], -1);
         idle_cycles($urandom_range(2, 5));
      end

      // asynchronous reset while the switch is driven high mid-bit
      run_txn(0, 1);
      @(posedge clock);
      #1 check_val("switch_before_reset", lnk.switch_control, m_sw());
      #1 reset = 1'b0;
      #1 check_val("switch_async_reset", lnk.switch_control, 0);
      check_val("busy_async_reset", lnk.busy, 0);
      model_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle_cycles(6);
      run_txn(0, -1);
      idle_cycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
